// File: rtl/spi1_pkg.sv
// ---------------------------------------------------------------------------
// spi1_pkg
// Shared definitions for the SPI1 target link: bus widths, the command opcode
// enum, the frame length for each opcode and the bus FSM state type.
// No ports (package).
// ---------------------------------------------------------------------------
package spi1_pkg;

    localparam int ADDR_WIDTH = 17;
    localparam int DATA_WIDTH = 8;

    // Command byte bits [7:6]; bit 0 selects read, bit 1 selects pointer-relative
    typedef enum logic [1:0] {
        OP_WRITE_AT   = 2'b00,
        OP_READ_AT    = 2'b01,
        OP_WRITE_NEXT = 2'b10,
        OP_READ_NEXT  = 2'b11
    } op_e;

    // Total frame length in bytes, command byte included
    localparam logic [2:0] LEN_WRITE_AT   = 3'd4;
    localparam logic [2:0] LEN_READ_AT    = 3'd3;
    localparam logic [2:0] LEN_WRITE_NEXT = 3'd2;
    localparam logic [2:0] LEN_READ_NEXT  = 3'd1;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_e;

    function automatic logic [2:0] frame_len(input op_e op);
        case (op)
            OP_WRITE_AT:   return LEN_WRITE_AT;
            OP_READ_AT:    return LEN_READ_AT;
            OP_WRITE_NEXT: return LEN_WRITE_NEXT;
            default:       return LEN_READ_NEXT;
        endcase
    endfunction

    function automatic logic op_is_read(input op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/spi1_shifter.sv
// ---------------------------------------------------------------------------
// spi1_shifter
// SPI mode 0 bit engine: synchronizes SCK/CS_N/SDI into the system clock,
// detects SCK and CS edges, assembles MSB-first bytes and shifts out a byte
// loaded at the start of each frame.
// Ports:
//   i_clk, i_rst_n      system clock, async active-low reset
//   i_sck, i_cs_n, i_sdi raw SPI pins (asynchronous)
//   i_loadData          byte presented on MISO during the first byte of a frame
//   o_sdo               MISO data
//   o_csActive          synchronized chip select is asserted
//   o_csFall, o_csRise  one-cycle strobes on synchronized CS edges
//   o_byteValid/o_byte  one-cycle strobe with each completed received byte
//   o_midByte           a byte is partially received (bit count nonzero)
// ---------------------------------------------------------------------------
module spi1_shifter (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sck,
    input  logic       i_cs_n,
    input  logic       i_sdi,
    input  logic [7:0] i_loadData,
    output logic       o_sdo,
    output logic       o_csActive,
    output logic       o_csFall,
    output logic       o_csRise,
    output logic       o_byteValid,
    output logic [7:0] o_byte,
    output logic       o_midByte
);

    logic [1:0] r_sckSync;
    logic [1:0] r_csSync;
    logic [1:0] r_sdiSync;
    logic       r_sckPrev;
    logic       r_csPrev;
    logic [2:0] r_bitCnt;
    logic [6:0] r_shIn;
    logic [7:0] r_shOut;
    logic       r_sdo;
    logic       r_byteValid;
    logic [7:0] r_byte;

    logic w_sckRise;
    logic w_sckFall;

    // SCK edges only count while the synchronized chip select is asserted
    assign w_sckRise = r_sckSync[1] & ~r_sckPrev & ~r_csSync[1];
    assign w_sckFall = ~r_sckSync[1] & r_sckPrev & ~r_csSync[1];

    assign o_csFall    = ~r_csSync[1] & r_csPrev;
    assign o_csRise    = r_csSync[1] & ~r_csPrev;
    assign o_csActive  = ~r_csSync[1];
    assign o_sdo       = r_sdo;
    assign o_byteValid = r_byteValid;
    assign o_byte      = r_byte;
    assign o_midByte   = (r_bitCnt != 3'd0);

    // Synchronizers plus the shift engine. A CS falling edge restarts the
    // bit count and puts the MSB of the load byte on MISO before the first
    // SCK rise; each SCK fall then advances MISO by one bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sckSync   <= 2'b00;
            r_csSync    <= 2'b11;
            r_sdiSync   <= 2'b00;
            r_sckPrev   <= 1'b0;
            r_csPrev    <= 1'b1;
            r_bitCnt    <= 3'd0;
            r_shIn      <= 7'd0;
            r_shOut     <= 8'd0;
            r_sdo       <= 1'b0;
            r_byteValid <= 1'b0;
            r_byte      <= 8'd0;
        end else begin
            r_sckSync   <= {r_sckSync[0], i_sck};
            r_csSync    <= {r_csSync[0], i_cs_n};
            r_sdiSync   <= {r_sdiSync[0], i_sdi};
            r_sckPrev   <= r_sckSync[1];
            r_csPrev    <= r_csSync[1];
            r_byteValid <= 1'b0;
            if (o_csFall) begin
                r_bitCnt <= 3'd0;
                r_shOut  <= i_loadData;
                r_sdo    <= i_loadData[7];
            end else if (o_csRise) begin
                r_sdo <= 1'b0;
            end else begin
                if (w_sckRise) begin
                    r_shIn   <= {r_shIn[5:0], r_sdiSync[1]};
                    r_bitCnt <= r_bitCnt + 3'd1;
                    if (r_bitCnt == 3'd7) begin
                        r_byteValid <= 1'b1;
                        r_byte      <= {r_shIn, r_sdiSync[1]};
                    end
                end
                if (w_sckFall) begin
                    r_shOut <= {r_shOut[6:0], 1'b0};
                    r_sdo   <= r_shOut[6];
                end
            end
        end
    end

endmodule

// File: rtl/spi1_target.sv
// ---------------------------------------------------------------------------
// spi1_target
// SPI1 responder for the MCU register/memory link. Decodes command frames,
// keeps a 17-bit address pointer and issues one bus read or write per frame
// to the arbiter. The latest read byte is returned on MISO in the next frame.
// Optional build macro SPI1_TARGET_FRAME_CHECK_EN adds frame_err_o and
// err_count_o for reporting malformed frames.
// Ports:
//   clk_i, reset_ni               system clock, async active-low reset
//   spi_sck_i/cs_ni/sdi_i         SPI pins from the MCU
//   spi_sdo_o, spi_sdo_oe         MISO and its output enable
//   spi_ready_no                  high while a transaction is pending
//   bus_req_o/ack_i/rw_no         arbiter handshake, rw_no 1 = read
//   bus_addr_o, bus_data_o        address and write data
//   bus_data_i                    read data, valid with bus_ack_i
//   frame_err_o, err_count_o      (macro only) error strobe and saturating count
// ---------------------------------------------------------------------------
module spi1_target
    import spi1_pkg::*;
#(
    parameter int CLK_MHZ = 64,
    parameter int SPI_MHZ = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  spi_sck_i,
    input  logic                  spi_cs_ni,
    input  logic                  spi_sdi_i,
    output logic                  spi_sdo_o,
    output logic                  spi_sdo_oe,
    output logic                  spi_ready_no,
    output logic                  bus_req_o,
    input  logic                  bus_ack_i,
    output logic                  bus_rw_no,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    input  logic [DATA_WIDTH-1:0] bus_data_i
`ifdef SPI1_TARGET_FRAME_CHECK_EN
    ,
    output logic                  frame_err_o,
    output logic [7:0]            err_count_o
`endif
);

    // The synchronizers and edge detector need several system clocks per SCK half period
    generate
        if (CLK_MHZ < 8 * SPI_MHZ) begin : g_clkCheck
            $error("spi1_target: CLK_MHZ must be at least 8*SPI_MHZ");
        end
    endgenerate

    logic                  w_csActive;
    logic                  w_csFall;
    logic                  w_csRise;
    logic                  w_byteValid;
    logic [7:0]            w_byte;
    logic                  w_midByte;
    op_e                   w_op;
    logic                  w_final;
    logic [ADDR_WIDTH-1:0] w_addr;

    logic [DATA_WIDTH-1:0] r_rdData;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [1:0]            r_byteIdx;
    logic                  r_done;
    op_e                   r_op;
    logic                  r_a16;
    logic [7:0]            r_addrHi;
    logic [7:0]            r_addrLo;
    state_e                r_state;

    spi1_shifter u_shifter (
        .i_clk       (clk_i),
        .i_rst_n     (reset_ni),
        .i_sck       (spi_sck_i),
        .i_cs_n      (spi_cs_ni),
        .i_sdi       (spi_sdi_i),
        .i_loadData  (r_rdData),
        .o_sdo       (spi_sdo_o),
        .o_csActive  (w_csActive),
        .o_csFall    (w_csFall),
        .o_csRise    (w_csRise),
        .o_byteValid (w_byteValid),
        .o_byte      (w_byte),
        .o_midByte   (w_midByte)
    );

    assign spi_sdo_oe = w_csActive;

    // The opcode is taken straight from the incoming byte while it is the
    // command byte, so single-byte READ_NEXT frames dispatch without waiting.
    // READ_AT finishes on addr_lo, which has not been registered yet.
    always_comb begin
        w_op    = (r_byteIdx == 2'd0) ? op_e'(w_byte[7:6]) : r_op;
        w_final = w_byteValid & ~r_done &
                  (({1'b0, r_byteIdx} + 3'd1) == frame_len(w_op));
        if (w_op[1]) begin
            w_addr = r_ptr + 17'd1;
        end else if (w_op == OP_READ_AT) begin
            w_addr = {r_a16, r_addrHi, w_byte};
        end else begin
            w_addr = {r_a16, r_addrHi, r_addrLo};
        end
    end

    // Frame decoder: tracks the byte index within the current frame and
    // stops accepting bytes once the final byte has been seen.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_byteIdx <= 2'd0;
            r_done    <= 1'b0;
            r_op      <= OP_WRITE_AT;
            r_a16     <= 1'b0;
            r_addrHi  <= 8'd0;
            r_addrLo  <= 8'd0;
        end else if (w_csFall) begin
            r_byteIdx <= 2'd0;
            r_done    <= 1'b0;
        end else if (w_byteValid && !r_done) begin
            case (r_byteIdx)
                2'd0: begin
                    r_op  <= w_op;
                    r_a16 <= w_byte[0];
                end
                2'd1:    r_addrHi <= w_byte;
                2'd2:    r_addrLo <= w_byte;
                default: ;
            endcase
            if (w_final) begin
                r_done <= 1'b1;
            end else begin
                r_byteIdx <= r_byteIdx + 2'd1;
            end
        end
    end

    // Bus FSM. Dispatch latches the transaction and raises spi_ready_no;
    // bus_req_o follows one cycle later and holds until the arbiter acks.
    // A final byte arriving while in REQ is dropped.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state      <= ST_IDLE;
            spi_ready_no <= 1'b0;
            bus_req_o    <= 1'b0;
            bus_rw_no    <= 1'b1;
            bus_addr_o   <= '0;
            bus_data_o   <= '0;
            r_ptr        <= '0;
            r_rdData     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_final) begin
                        bus_addr_o   <= w_addr;
                        r_ptr        <= w_addr;
                        bus_rw_no    <= op_is_read(w_op);
                        if (!op_is_read(w_op)) begin
                            bus_data_o <= w_byte;
                        end
                        spi_ready_no <= 1'b1;
                        r_state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!bus_req_o) begin
                        bus_req_o <= 1'b1;
                    end else if (bus_ack_i) begin
                        if (bus_rw_no) begin
                            r_rdData <= bus_data_i;
                        end
                        bus_req_o    <= 1'b0;
                        spi_ready_no <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI1_TARGET_FRAME_CHECK_EN
    // A frame is malformed if CS rises mid-byte or after some but not all
    // of its bytes; the counter saturates rather than wrapping.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            frame_err_o <= 1'b0;
            err_count_o <= 8'd0;
        end else begin
            frame_err_o <= 1'b0;
            if (w_csRise && (w_midByte || (r_byteIdx != 2'd0 && !r_done))) begin
                frame_err_o <= 1'b1;
                if (err_count_o != 8'hFF) begin
                    err_count_o <= err_count_o + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi1_target.sv
// ---------------------------------------------------------------------------
// tb_spi1_target
// Bench for spi1_target: an SPI mode 0 master drives command frames at 4 MHz
// against a 64 MHz system clock, a simple arbiter answers bus requests, and a
// transaction-level model (pointer, last read byte) predicts every result.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi1_target;

    localparam real CLK_HALF = 7.8125;
    localparam real SCK_HALF = 125.0;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        spi_sck_i;
    logic        spi_cs_ni;
    logic        spi_sdi_i;
    logic        spi_sdo_o;
    logic        spi_sdo_oe;
    logic        spi_ready_no;
    logic        bus_req_o;
    logic        bus_ack_i;
    logic        bus_rw_no;
    logic [16:0] bus_addr_o;
    logic [7:0]  bus_data_o;
    logic [7:0]  bus_data_i;
`ifdef SPI1_TARGET_FRAME_CHECK_EN
    logic        frame_err_o;
    logic [7:0]  err_count_o;
    int          errPulses = 0;
`endif

    always #(CLK_HALF) clk_i = ~clk_i;

    spi1_target #(.CLK_MHZ(64), .SPI_MHZ(4)) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .spi_sck_i    (spi_sck_i),
        .spi_cs_ni    (spi_cs_ni),
        .spi_sdi_i    (spi_sdi_i),
        .spi_sdo_o    (spi_sdo_o),
        .spi_sdo_oe   (spi_sdo_oe),
        .spi_ready_no (spi_ready_no),
        .bus_req_o    (bus_req_o),
        .bus_ack_i    (bus_ack_i),
        .bus_rw_no    (bus_rw_no),
        .bus_addr_o   (bus_addr_o),
        .bus_data_o   (bus_data_o),
        .bus_data_i   (bus_data_i)
`ifdef SPI1_TARGET_FRAME_CHECK_EN
        ,
        .frame_err_o  (frame_err_o),
        .err_count_o  (err_count_o)
`endif
    );

    int checkCnt = 0;
    int passCnt  = 0;
    int failCnt  = 0;

    // Model state: address pointer and read-data register as the MCU sees them
    logic [16:0] modelPtr  = 17'd0;
    logic [7:0]  modelRead = 8'd0;
    logic [7:0]  frameBytes [6];

    // Arbiter state
    logic        holdAck     = 1'b1;
    logic [7:0]  nextAckData = 8'd0;
    int          busCycles   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Arbiter: records each request, checks the request stays stable with
    // spi_ready_no high, and acks after a random delay unless held off.
    initial begin : arbiter
        bit          inReq;
        int          ackDelay;
        logic [26:0] seen;
        inReq    = 1'b0;
        ackDelay = 0;
        seen     = '0;
        forever begin
            @(negedge clk_i);
            bus_ack_i = 1'b0;
            if (bus_req_o === 1'b1) begin
                if (!inReq) begin
                    inReq    = 1'b1;
                    busCycles++;
                    seen     = {bus_addr_o, bus_data_o, bus_rw_no, spi_ready_no};
                    ackDelay = $urandom_range(0, 4);
                end else begin
                    checkOutput("busStable", {5'd0, bus_addr_o, bus_data_o, bus_rw_no, spi_ready_no},
                                {5'd0, seen});
                end
                if (!holdAck) begin
                    if (ackDelay == 0) begin
                        bus_ack_i  = 1'b1;
                        bus_data_i = nextAckData;
                    end else begin
                        ackDelay--;
                    end
                end
            end else begin
                inReq = 1'b0;
            end
        end
    end

    // MISO enable follows chip select once it has been stable past the synchronizer
    initial begin : oeMonitor
        logic csPrev;
        int   stable;
        csPrev = 1'b1;
        stable = 0;
        forever begin
            @(negedge clk_i);
            if (spi_cs_ni === csPrev) stable++;
            else stable = 0;
            csPrev = spi_cs_ni;
            if (reset_ni === 1'b1 && stable >= 4)
                checkOutput("sdoOe", {31'd0, spi_sdo_oe}, {31'd0, ~spi_cs_ni});
        end
    end

`ifdef SPI1_TARGET_FRAME_CHECK_EN
    always @(negedge clk_i) if (frame_err_o === 1'b1) errPulses++;
`endif

    task automatic spiXfer(input logic [7:0] tx, input int nBits, output logic [7:0] rx);
        rx = 8'd0;
        for (int i = 7; i >= 8 - nBits; i--) begin
            spi_sdi_i = tx[i];
            #(SCK_HALF);
            spi_sck_i = 1'b1;
            rx[i]     = spi_sdo_o;
            #(SCK_HALF);
            spi_sck_i = 1'b0;
        end
    endtask

    // Send nFull whole bytes of frameBytes then partBits of the next, leaving CS low
    task automatic applyStimulus(input int nFull, input int partBits, output logic [7:0] rx0);
        logic [7:0] rx;
        rx0       = 8'd0;
        spi_cs_ni = 1'b0;
        #(SCK_HALF);
        for (int b = 0; b < nFull; b++) begin
            spiXfer(frameBytes[b], 8, rx);
            if (b == 0) rx0 = rx;
        end
        if (partBits > 0) spiXfer(frameBytes[nFull], partBits, rx);
        #(SCK_HALF);
    endtask

    task automatic runFrame(input int nFull, input int partBits, input logic [7:0] ackData);
        logic [1:0]  op;
        int          len;
        bit          expDispatch;
        logic [16:0] expAddr;
        logic        expRead;
        logic [7:0]  expData;
        logic [7:0]  rx0;
        int          cyclesBefore;
`ifdef SPI1_TARGET_FRAME_CHECK_EN
        int          errBefore;
        errBefore = errPulses;
`endif
        op          = frameBytes[0][7:6];
        len         = (op == 2'd0) ? 4 : (op == 2'd1) ? 3 : (op == 2'd2) ? 2 : 1;
        expDispatch = (nFull >= len);
        expRead     = op[0];
        expAddr     = op[1] ? 17'((32'(modelPtr) + 1) % 32'h20000)
                            : {frameBytes[0][0], frameBytes[1], frameBytes[2]};
        expData     = (op == 2'd0) ? frameBytes[3] : frameBytes[1];
        cyclesBefore = busCycles;
        nextAckData  = ackData;
        holdAck      = 1'b1;

        applyStimulus(nFull, partBits, rx0);
        if (nFull > 0) checkOutput("misoByte0", {24'd0, rx0}, {24'd0, modelRead});

        if (expDispatch) begin
            checkOutput("readyPending", {31'd0, spi_ready_no}, 32'd1);
            checkOutput("reqAsserted", {31'd0, bus_req_o}, 32'd1);
            checkOutput("busAddr", {15'd0, bus_addr_o}, {15'd0, expAddr});
            checkOutput("busRwN", {31'd0, bus_rw_no}, {31'd0, expRead});
            if (!expRead) checkOutput("busData", {24'd0, bus_data_o}, {24'd0, expData});
            modelPtr  = expAddr;
            spi_cs_ni = 1'b1;
            repeat (4) @(negedge clk_i);
            holdAck = 1'b0;
            for (int k = 0; k < 200 && bus_req_o !== 1'b0; k++) @(negedge clk_i);
            checkOutput("reqReleased", {31'd0, bus_req_o}, 32'd0);
            checkOutput("readyDone", {31'd0, spi_ready_no}, 32'd0);
            if (expRead) modelRead = ackData;
            checkOutput("cycleCount", busCycles, cyclesBefore + 1);
        end else begin
            spi_cs_ni = 1'b1;
            repeat (10) @(negedge clk_i);
            checkOutput("noReq", {31'd0, bus_req_o}, 32'd0);
            checkOutput("noReady", {31'd0, spi_ready_no}, 32'd0);
            checkOutput("noCycle", busCycles, cyclesBefore);
        end
        repeat (8) @(negedge clk_i);
`ifdef SPI1_TARGET_FRAME_CHECK_EN
        checkOutput("frameErrPulses", errPulses - errBefore, expDispatch ? 0 : 1);
`endif
    endtask

    task automatic setFrame(input logic [7:0] b0, b1, b2, b3);
        frameBytes[0] = b0;
        frameBytes[1] = b1;
        frameBytes[2] = b2;
        frameBytes[3] = b3;
        frameBytes[4] = 8'h00;
        frameBytes[5] = 8'h00;
    endtask

    initial begin : main
        logic [7:0] rx0;
        reset_ni   = 1'b1;
        spi_cs_ni  = 1'b1;
        spi_sck_i  = 1'b0;
        spi_sdi_i  = 1'b0;
        bus_ack_i  = 1'b0;
        bus_data_i = 8'd0;
        #3 reset_ni = 1'b0;
        repeat (4) @(negedge clk_i);
        checkOutput("rstSdo", {31'd0, spi_sdo_o}, 32'd0);
        checkOutput("rstOe", {31'd0, spi_sdo_oe}, 32'd0);
        checkOutput("rstReady", {31'd0, spi_ready_no}, 32'd0);
        checkOutput("rstReq", {31'd0, bus_req_o}, 32'd0);
        checkOutput("rstRwN", {31'd0, bus_rw_no}, 32'd1);
        checkOutput("rstAddr", {15'd0, bus_addr_o}, 32'd0);
        checkOutput("rstData", {24'd0, bus_data_o}, 32'd0);
        reset_ni = 1'b1;
        repeat (6) @(negedge clk_i);

        $display("[TB] WRITE_AT 0x18000");
        setFrame(8'h01, 8'h80, 8'h00, 8'h55);
        runFrame(4, 0, 8'h00);

        $display("[TB] READ_AT 0x01234 then READ_NEXT");
        setFrame(8'h40, 8'h12, 8'h34, 8'h00);
        runFrame(3, 0, 8'hA5);
        setFrame(8'hC0, 8'h00, 8'h00, 8'h00);
        runFrame(1, 0, 8'h3C);

        $display("[TB] pointer wrap");
        setFrame(8'h01, 8'hFF, 8'hFF, 8'h77);
        runFrame(4, 0, 8'h00);
        setFrame(8'h80, 8'h11, 8'h00, 8'h00);
        runFrame(2, 0, 8'h00);
        checkOutput("wrapAddr", {15'd0, modelPtr}, 32'd0);

        $display("[TB] truncated frame");
        setFrame(8'h00, 8'h12, 8'h34, 8'h56);
        runFrame(2, 5, 8'h00);
`ifdef SPI1_TARGET_FRAME_CHECK_EN
        checkOutput("errCount", {24'd0, err_count_o}, 32'd1);
`endif

        $display("[TB] reset during pending request");
        setFrame(8'h40, 8'h00, 8'h10, 8'h00);
        holdAck = 1'b1;
        applyStimulus(3, 0, rx0);
        checkOutput("preRstReq", {31'd0, bus_req_o}, 32'd1);
        @(negedge clk_i);
        #2 reset_ni = 1'b0;
        #1;
        checkOutput("asyncRstReq", {31'd0, bus_req_o}, 32'd0);
        checkOutput("asyncRstReady", {31'd0, spi_ready_no}, 32'd0);
        checkOutput("asyncRstAddr", {15'd0, bus_addr_o}, 32'd0);
        spi_cs_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        reset_ni  = 1'b1;
        modelPtr  = 17'd0;
        modelRead = 8'd0;
        repeat (6) @(negedge clk_i);
        setFrame(8'hC0, 8'h00, 8'h00, 8'h00);
        runFrame(1, 0, 8'h9E);
        checkOutput("postRstPtr", {15'd0, bus_addr_o}, 32'd1);

        $display("[TB] randomized frames");
        for (int n = 0; n < 24; n++) begin
            int len;
            int nFull;
            int partBits;
            for (int b = 0; b < 6; b++) frameBytes[b] = 8'($urandom);
            len = (frameBytes[0][7:6] == 2'd0) ? 4 : (frameBytes[0][7:6] == 2'd1) ? 3 :
                  (frameBytes[0][7:6] == 2'd2) ? 2 : 1;
            if ($urandom_range(0, 3) == 0) begin
                nFull    = $urandom_range(0, len - 1);
                partBits = $urandom_range((nFull == 0) ? 1 : 0, 7);
            end else begin
                nFull    = len + $urandom_range(0, 2);
                partBits = 0;
            end
            runFrame(nFull, partBits, 8'($urandom));
        end

        $display("[TB] %0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
